// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: 7-bit addressed I2C target with an auto-incrementing byte register bank.
// Ports: clk, rst_n (synchronous, active-low); scl_i/sda_i raw pin levels; sda_oe=1 pulls SDA low;
// regs is the flat bank (reg k at [8k+7:8k]); wr_strobe/wr_index flag each committed data byte;
// busy is high while this target is addressed.
// Define I2C_GENERAL_CALL_EN to also ACK writes to address 7'h00 (general call).
module i2c_slave_regbank #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h08,
    parameter int         NUM_REGS    = 4,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [8*NUM_REGS-1:0] regs,
    output logic                  wr_strobe,
    output logic [PW-1:0]         wr_index,
    output logic                  busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_h_q, sda_h_q;
    logic [2:0]             cnt_q;
    logic [6:0]             sh_q;
    logic                   rd_q, nack_q;
    logic [PW-1:0]          ptr_q, wr_index_q;
    logic                   sda_oe_q, wr_strobe_q, busy_q;
    logic [7:0]             regs_q [NUM_REGS];
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, addr_match;
    logic [7:0]             rx_byte;
    logic [PW-1:0]          ptr_inc;
    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_h_q;
    assign scl_fall  = ~scl_s & scl_h_q;
    // SCL must be high in both samples, so a same-sample SCL+SDA change is just a data bit
    assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
    assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;
    assign rx_byte   = {sh_q, sda_s};
    assign ptr_inc   = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
`ifdef I2C_GENERAL_CALL_EN
    assign addr_match = (rx_byte[7:1] == SLAVE_ADDR) || (rx_byte == 8'h00);
`else
    assign addr_match = rx_byte[7:1] == SLAVE_ADDR;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_h_q     <= 1'b1;
            sda_h_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            rd_q        <= 1'b0;
            nack_q      <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_h_q     <= scl_s;
            sda_h_q     <= sda_s;
            wr_strobe_q <= 1'b0;
            if (start_det) begin
                state_q  <= ADDR;
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
            end else if (stop_det) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    // cnt_q wraps back to 0 on the 8th sampled bit
                    ADDR, PTR, WDATA: if (scl_rise) begin
                        sh_q  <= rx_byte[6:0];
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                state_q <= addr_match ? ADDR_ACK : WAIT_STOP;
                                busy_q  <= addr_match;
                                rd_q    <= rx_byte[0];
                            end else if (state_q == PTR) begin
                                ptr_q   <= PW'(rx_byte % NUM_REGS);
                                state_q <= PTR_ACK;
                            end else begin
                                regs_q[ptr_q] <= rx_byte;
                                wr_strobe_q   <= 1'b1;
                                wr_index_q    <= ptr_q;
                                ptr_q         <= ptr_inc;
                                state_q       <= WDATA_ACK;
                            end
                        end
                    end
                    // first falling edge starts the ACK, second one ends it
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_q <= 1'b1;
                        end else if (state_q == ADDR_ACK && rd_q) begin
                            state_q  <= RDATA;
                            sh_q     <= regs_q[ptr_q][6:0];
                            sda_oe_q <= ~regs_q[ptr_q][7];
                        end else begin
                            state_q  <= (state_q == ADDR_ACK) ? PTR : WDATA;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    RDATA: if (scl_fall) begin
                        cnt_q    <= cnt_q + 3'd1;
                        sh_q     <= {sh_q[5:0], 1'b0};
                        sda_oe_q <= (cnt_q == 3'd7) ? 1'b0 : ~sh_q[6];
                        state_q  <= (cnt_q == 3'd7) ? RDATA_ACK : RDATA;
                    end
                    RDATA_ACK: begin
                        if (scl_rise) nack_q <= sda_s;
                        if (scl_fall) begin
                            if (nack_q) begin
                                state_q <= WAIT_STOP;
                            end else begin
                                ptr_q    <= ptr_inc;
                                sh_q     <= regs_q[ptr_inc][6:0];
                                sda_oe_q <= ~regs_q[ptr_inc][7];
                                state_q  <= RDATA;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs[8*k +: 8] = regs_q[k];
    end
endmodule

// File: tb/tb_i2c_slave_regbank.sv
// tb_i2c_slave_regbank: bit-banged I2C master against a transaction-level register model.
module tb_i2c_slave_regbank;
    localparam logic [6:0] SA = 7'h08;
    localparam int         N  = 4;
    localparam int         Q  = 5;
`ifdef I2C_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif
    logic           clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic           sda_oe, wr_strobe, busy, sda_line;
    logic [8*N-1:0] regs;
    logic [1:0]     wr_index;
    assign sda_line = sda_m & ~sda_oe;
    i2c_slave_regbank #(.SLAVE_ADDR(SA), .NUM_REGS(N), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .regs(regs), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );
    always #5 clk = ~clk;
    int         checks = 0, errors = 0;
    logic [7:0] m_regs [N];
    int         m_ptr;
    int         exp_st[$], got_st[$];
    logic [7:0] tx_q[$];
    int         oe_cnt = 0, busy_cnt = 0, strobe_dbl = 0;
    logic       strobe_prev = 1'b0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (wr_strobe) got_st.push_back({wr_index, regs[8*wr_index +: 8]});
        if (wr_strobe && strobe_prev) strobe_dbl <= strobe_dbl + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        strobe_prev <= wr_strobe;
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic clock_bit(input logic v, output logic s, output logic oe);
        tick(Q); sda_m = v;
        tick(Q); scl_m = 1'b1;
        tick(Q); s = sda_line; oe = sda_oe;
        tick(Q); scl_m = 1'b0;
    endtask
    task automatic start_c;
        tick(Q); sda_m = 1'b1;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b0;
    endtask
    task automatic stop_c;
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b1;
        tick(2*Q);
    endtask
    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s, oe;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s, oe);
        clock_bit(1'b1, s, oe);
        ack = ~s;
    endtask
    task automatic recv_byte(input logic nack, output logic [7:0] b, output logic oe_ack);
        logic s, oe;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s, oe);
            b[i] = s;
        end
        clock_bit(nack, s, oe_ack);
    endtask
    task automatic end_txn;
        stop_c();
        check("busy_after_stop", busy, 1'b0);
        check("strobe_count", got_st.size(), exp_st.size());
        foreach (exp_st[i]) if (i < got_st.size()) check("strobe_idx_data", got_st[i], exp_st[i]);
        for (int k = 0; k < N; k++) check($sformatf("reg%0d", k), regs[8*k +: 8], m_regs[k]);
        check("strobe_width", strobe_dbl, 0);
        got_st.delete();
        exp_st.delete();
    endtask
    task automatic wr_txn(input logic [6:0] a, input bit do_stop);
        logic ack;
        bit   match;
        match = (a == SA) || (GC && a == 7'h00);
        start_c();
        send_byte({a, 1'b0}, ack);
        check("waddr_ack", ack, match);
        check("busy_addressed", busy, match);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], ack);
            check($sformatf("wbyte%0d_ack", i), ack, match);
            if (match && i == 0) begin
                m_ptr = tx_q[i] % N;
            end else if (match) begin
                m_regs[m_ptr] = tx_q[i];
                exp_st.push_back(m_ptr * 256 + tx_q[i]);
                m_ptr = (m_ptr + 1) % N;
            end
        end
        if (do_stop) end_txn();
    endtask
    task automatic rd_txn(input logic [6:0] a, input int n);
        logic       ack, oe;
        logic [7:0] b;
        bit         match;
        match = a == SA;
        start_c();
        send_byte({a, 1'b1}, ack);
        check("raddr_ack", ack, match);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b, oe);
            check($sformatf("rdata%0d", i), b, match ? m_regs[m_ptr] : 8'hFF);
            check("master_ack_oe", oe, 1'b0);
            if (match && i != n - 1) m_ptr = (m_ptr + 1) % N;
        end
        end_txn();
    endtask
    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic [6:0] a;
        logic       s, oe;
        int         n, o0, b0;
        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
        tick(3);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_index", wr_index, 2'd0);
        check("rst_regs", regs, 32'h0);
        rst_n = 1'b1;
        tick(5);
        tx_q = '{8'h01, 8'hAA, 8'hBB, 8'hCC};
        wr_txn(SA, 1);
        tx_q = '{8'h03, 8'h11, 8'h22};
        wr_txn(SA, 1);
        tx_q = '{8'h02};
        wr_txn(SA, 0);
        rd_txn(SA, 2);
        tx_q = '{8'h01};
        wr_txn(SA, 1);
        rd_txn(SA, 3);
        o0 = oe_cnt;
        b0 = busy_cnt;
        tx_q = '{8'h55};
        wr_txn(7'h09, 1);
        check("mismatch_oe_cycles", oe_cnt - o0, 0);
        check("mismatch_busy_cycles", busy_cnt - b0, 0);
        tx_q = '{8'h00, 8'h5A};
        wr_txn(7'h00, 1);
        start_c();
        send_byte({SA, 1'b0}, s);
        send_byte(8'h01, s);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s, oe);
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b1;
        rst_n = 1'b0;
        tick(1);
        check("midrst_sda_oe", sda_oe, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_strobe", wr_strobe, 1'b0);
        check("midrst_index", wr_index, 2'd0);
        check("midrst_regs", regs, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
        got_st.delete();
        exp_st.delete();
        tick(Q); scl_m = 1'b0;
        stop_c();
        tx_q = '{8'h02, 8'h3C, 8'hC3, 8'h7E};
        wr_txn(SA, 1);
        rd_txn(SA, 2);
        for (int it = 0; it < 16; it++) begin
            a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : SA;
            case ($urandom_range(0, 2))
                0: begin
                    tx_q.delete();
                    n = $urandom_range(0, 5);
                    for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
                    wr_txn(a, 1);
                end
                1: begin
                    tx_q = '{8'($urandom)};
                    wr_txn(SA, 0);
                    rd_txn(a, $urandom_range(1, 4));
                end
                default: rd_txn(a, $urandom_range(1, 3));
            endcase
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
